// File: rtl/knn_topk_sorter.sv
// knn_topk_sorter
//   Keeps the K nearest (distance, label) pairs of one query in a sorted list,
//   then drains them nearest-first to the KNN vote logic.
//
//   Insertion is a parallel compare/shift, one sample per clock. Every slot
//   compares its own distance against the candidate. Because the list is kept
//   sorted, the "slot <= candidate" flags form a thermometer code. The
//   candidate lands in the first slot whose flag is clear. Slots past that
//   point take their predecessor's contents, and slot K-1 falls off the end.
//
// Ports
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   clear                       synchronous abort: empty the list and go to ACCEPT
//   in_valid/in_ready           sample handshake (in_ready is high only in ACCEPT)
//   in_dist, in_label, in_last  candidate sample; in_last marks the final sample
//   out_valid/out_ready         drain handshake
//   out_dist, out_label         entry being presented
//   out_rank                    index of that entry, 0 = nearest
//   out_last                    final entry of the drain
//   busy                        high while draining
module knn_topk_sorter #(
  parameter int K       = 10,
  parameter int DIST_W  = 32,
  parameter int LABEL_W = 8,
  parameter int RANK_W  = (K > 1) ? $clog2(K) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIST_W-1:0]  in_dist,
  input  logic [LABEL_W-1:0] in_label,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIST_W-1:0]  out_dist,
  output logic [LABEL_W-1:0] out_label,
  output logic [RANK_W-1:0]  out_rank,
  output logic               out_last,
  output logic               busy
);

  localparam int CNT_W = $clog2(K + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_DRAIN
  } state_t;

  state_t state_reg, state_next;

  logic [DIST_W-1:0]  dist_reg  [K];
  logic [LABEL_W-1:0] label_reg [K];
  logic [K-1:0]       valid_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [RANK_W-1:0]  rank_reg;

  // Per-slot insertion decode.
  logic [K-1:0]       le;         // slot holds a valid entry with dist <= in_dist
  logic [K-1:0]       take_new;   // slot receives the incoming sample
  logic [K-1:0]       take_prev;  // slot receives the contents of slot-1
  logic [DIST_W-1:0]  prev_dist  [K];
  logic [LABEL_W-1:0] prev_label [K];
  logic [K-1:0]       prev_valid;

  logic in_fire, out_fire, drain_done;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      // "<=" sends a new sample behind existing equal distances. The earlier
      // sample therefore keeps the lower rank. A full list whose worst entry
      // equals in_dist sets every flag, and the sample is discarded.
      assign le[gi] = valid_reg[gi] && (dist_reg[gi] <= in_dist);
      if (gi == 0) begin : g_head
        assign take_new[gi]   = !le[gi];
        assign take_prev[gi]  = 1'b0;
        assign prev_dist[gi]  = '0;
        assign prev_label[gi] = '0;
        assign prev_valid[gi] = 1'b0;
      end else begin : g_tail
        assign take_new[gi]   = !le[gi] && le[gi-1];
        assign take_prev[gi]  = !le[gi-1];
        assign prev_dist[gi]  = dist_reg[gi-1];
        assign prev_label[gi] = label_reg[gi-1];
        assign prev_valid[gi] = valid_reg[gi-1];
      end
    end
  endgenerate

  assign in_ready  = (state_reg == S_ACCEPT);
  assign out_valid = (state_reg == S_DRAIN);
  assign busy      = (state_reg == S_DRAIN);

  // clear outranks both handshakes that happen in the same cycle.
  assign in_fire    = in_valid && in_ready && !clear;
  assign out_fire   = out_valid && out_ready && !clear;
  assign drain_done = out_fire && out_last;

  assign out_last = out_valid && (CNT_W'(rank_reg) == (count_reg - CNT_W'(1)));
  assign out_rank = out_valid ? rank_reg : '0;

  // Read mux for the entry selected by the drain pointer. It is forced to zero
  // outside DRAIN, so no stale list contents reach the outputs.
  always_comb begin
    out_dist  = '0;
    out_label = '0;
    if (out_valid) begin
      for (int i = 0; i < K; i++) begin
        if (rank_reg == RANK_W'(i)) begin
          out_dist  = dist_reg[i];
          out_label = label_reg[i];
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   state_next = S_ACCEPT;
      S_ACCEPT: if (in_fire && in_last) state_next = S_DRAIN;
      S_DRAIN:  if (drain_done) state_next = S_ACCEPT;
      default:  state_next = S_IDLE;
    endcase
    if (clear) state_next = S_ACCEPT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      rank_reg  <= '0;
      valid_reg <= '0;
      for (int i = 0; i < K; i++) begin
        dist_reg[i]  <= '0;
        label_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (clear || drain_done) begin
        valid_reg <= '0;
        count_reg <= '0;
        rank_reg  <= '0;
      end else begin
        if (in_fire) begin
          for (int i = 0; i < K; i++) begin
            if (take_new[i]) begin
              dist_reg[i]  <= in_dist;
              label_reg[i] <= in_label;
              valid_reg[i] <= 1'b1;
            end else if (take_prev[i]) begin
              dist_reg[i]  <= prev_dist[i];
              label_reg[i] <= prev_label[i];
              valid_reg[i] <= prev_valid[i];
            end
          end
          if (count_reg != CNT_W'(K)) count_reg <= count_reg + CNT_W'(1);
        end
        if (out_fire) rank_reg <= rank_reg + RANK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_knn_topk_sorter.sv
// tb_knn_topk_sorter
//   Directed and randomized queries for knn_topk_sorter (K=3). The reference
//   model collects every sample of a query. It then selects the K smallest
//   distances by repeated minimum search, and on equal distances the earlier
//   arrival wins. The drain is compared entry by entry against that model.
module tb_knn_topk_sorter;
  localparam int K  = 3;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_dist = '0;
  logic [LW-1:0] in_label = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_dist;
  logic [LW-1:0] out_label;
  logic [RW-1:0] out_rank;
  logic          out_last;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] qd[$];
  logic [LW-1:0] ql[$];
  logic [DW-1:0] ed[$];
  logic [LW-1:0] el[$];

  knn_topk_sorter #(.K(K), .DIST_W(DW), .LABEL_W(LW), .RANK_W(RW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
    .in_label(in_label), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist),
    .out_label(out_label), .out_rank(out_rank), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected drain contents: the K smallest distances, ascending, with ties
  // resolved in arrival order.
  task automatic build_model();
    bit used[];
    int best;
    int n;
    n = qd.size();
    used = new[n];
    ed.delete();
    el.delete();
    for (int r = 0; r < K && r < n; r++) begin
      best = -1;
      for (int j = 0; j < n; j++)
        if (!used[j] && (best < 0 || qd[j] < qd[best])) best = j;
      used[best] = 1'b1;
      ed.push_back(qd[best]);
      el.push_back(ql[best]);
    end
  endtask

  task automatic send_all(input bit last_flag);
    int w;
    for (int i = 0; i < qd.size(); i++) begin
      in_valid = 1'b1;
      in_dist  = qd[i];
      in_label = ql[i];
      in_last  = last_flag && (i == qd.size() - 1);
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
        step();
        w++;
      end
      if (w == 20) check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input bit bp, input bit junk);
    int m, idx, cyc;
    build_model();
    m = ed.size();
    idx = 0;
    cyc = 0;
    while (idx < m && cyc < 300) begin
      check("out_valid", {63'b0, out_valid}, 64'd1);
      check("in_ready_drain", {63'b0, in_ready}, 64'd0);
      check("busy", {63'b0, busy}, 64'd1);
      check("out_dist", {32'b0, out_dist}, {32'b0, ed[idx]});
      check("out_label", {56'b0, out_label}, {56'b0, el[idx]});
      check("out_rank", {62'b0, out_rank}, idx);
      check("out_last", {63'b0, out_last}, (idx == m - 1) ? 64'd1 : 64'd0);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      // Samples offered during the drain must be ignored.
      in_valid  = junk && !(out_ready && idx == m - 1);
      in_dist   = $urandom;
      in_label  = 8'($urandom);
      step();
      if (out_ready) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drain_beats", idx, m);
    check("out_valid_after", {63'b0, out_valid}, 64'd0);
    check("in_ready_after", {63'b0, in_ready}, 64'd1);
    $display("query n=%0d drained=%0d bp=%0d", qd.size(), idx, bp);
  endtask

  task automatic run_query(input bit bp, input bit junk);
    send_all(1'b1);
    drain(bp, junk);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_out_dist", {32'b0, out_dist}, 64'd0);
    check("rst_out_last", {63'b0, out_last}, 64'd0);
    step();
    step();
    rst = 1'b0;
    check("idle_in_ready", {63'b0, in_ready}, 64'd0);
    step();
    check("accept_in_ready", {63'b0, in_ready}, 64'd1);

    // Basic sort
    qd = '{32'd5, 32'd3, 32'd9, 32'd1};
    ql = '{8'd0, 8'd1, 8'd2, 8'd3};
    run_query(1'b0, 1'b0);

    // Ties
    qd = '{32'd4, 32'd4, 32'd2};
    ql = '{8'hA, 8'hB, 8'hC};
    run_query(1'b0, 1'b0);

    // Underfill
    qd = '{32'd7, 32'd6};
    ql = '{8'd70, 8'd60};
    run_query(1'b0, 1'b0);

    // Backpressure, with samples offered during the drain
    qd = '{32'd12, 32'd40, 32'd3, 32'd12, 32'd8, 32'd1};
    ql = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    run_query(1'b1, 1'b1);

    // Boundary distances; a second max-distance sample equals the worst entry
    qd = '{32'd0, 32'hFFFF_FFFF, 32'd10, 32'hFFFF_FFFF};
    ql = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_query(1'b1, 1'b0);

    // clear after two samples; a sample presented with clear is dropped
    qd = '{32'd20, 32'd30};
    ql = '{8'd1, 8'd2};
    send_all(1'b0);
    in_valid = 1'b1;
    in_dist  = 32'd1;
    in_label = 8'd99;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_in_ready", {63'b0, in_ready}, 64'd1);
    check("clear_out_valid", {63'b0, out_valid}, 64'd0);
    qd = '{32'd8, 32'd2};
    ql = '{8'd8, 8'd2};
    run_query(1'b0, 1'b0);

    // clear while draining
    qd = '{32'd5, 32'd6};
    ql = '{8'd5, 8'd6};
    send_all(1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_drain_out_valid", {63'b0, out_valid}, 64'd0);
    check("clear_drain_in_ready", {63'b0, in_ready}, 64'd1);

    // rst while draining
    qd = '{32'd3, 32'd1, 32'd2};
    ql = '{8'd3, 8'd1, 8'd2};
    send_all(1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_mid_busy", {63'b0, busy}, 64'd0);
    check("rst_mid_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_mid_out_dist", {32'b0, out_dist}, 64'd0);
    step();
    rst = 1'b0;
    step();
    check("rst_mid_accept", {63'b0, in_ready}, 64'd1);
    qd = '{32'd9, 32'd4};
    ql = '{8'd9, 8'd4};
    run_query(1'b0, 1'b0);

    // Randomized queries
    for (int q = 0; q < 20; q++) begin
      int n;
      n = $urandom_range(1, 8);
      qd.delete();
      ql.delete();
      for (int i = 0; i < n; i++) begin
        qd.push_back(($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12)));
        ql.push_back(8'($urandom));
      end
      run_query(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
